wb_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back datapath for the 5-stage MIPS pipeline.
//  - Sole driver of the register file write port: wwreg, wdestReg, wbData.
//  - Updates on posedge clk. The register file commits on the following negedge,
//    so the ID-stage read in the same cycle sees the value.
//  - Also performs load-data alignment and extension, and counts retired instructions.

---
 rtl/mips_pkg.sv | 11 +
 rtl/load_align.sv | 39 +++
 rtl/wb_stage.sv | 66 ++++++
 tb/tb_wb_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths, load-size encodings and the $0 specifier.
package mips_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] LSIZE_WORD = 2'b00;
    localparam logic [1:0] LSIZE_HALF = 2'b01;
    localparam logic [1:0] LSIZE_BYTE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_align.sv
// Big-endian load alignment and extension of a word-aligned memory read.
// Purely combinational; shared by the write-back stage and the forwarding path.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] mdo,
    input  logic [1:0]  addr,
    input  logic [1:0]  lsize,
    input  logic        lsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mdo[31:24];
        case (addr)
            2'd0: byte_sel = mdo[31:24];
            2'd1: byte_sel = mdo[23:16];
            2'd2: byte_sel = mdo[15:8];
            2'd3: byte_sel = mdo[7:0];
            default: byte_sel = mdo[31:24];
        endcase
    end

    // Halfword select ignores addr[0]; misaligned halves are not trapped here.
    assign half_sel = addr[1] ? mdo[15:0] : mdo[31:16];

    always_comb begin
        result = mdo;
        case (lsize)
            LSIZE_HALF: result = {{16{lsigned & half_sel[15]}}, half_sel};
            LSIZE_BYTE: result = {{24{lsigned & byte_sel[7]}}, byte_sel};
            default:    result = mdo;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back datapath; sole driver of the register-file write port.
// Also counts instructions captured into WB (wrapping counter).
module wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mvalid,
    input  logic                  mwreg,
    input  logic                  mm2reg,
    input  logic [REG_ADDR_W-1:0] mdestReg,
    input  logic [DATA_W-1:0]     mr,
    input  logic [DATA_W-1:0]     mdo,
    input  logic [1:0]            mlsize,
    input  logic                  mlsigned,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  wwreg,
    output logic [REG_ADDR_W-1:0] wdestReg,
    output logic [DATA_W-1:0]     wbData,
    output logic                  wvalid,
    output logic [CNT_W-1:0]      retired
);

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wb_next;
    logic              wwreg_next;

    load_align u_load_align (
        .mdo     (mdo),
        .addr    (mr[1:0]),
        .lsize   (mlsize),
        .lsigned (mlsigned),
        .result  (load_data)
    );

    assign wb_next    = mm2reg ? load_data : mr;
    // Bubbles and writes to $0 never reach the register file.
    assign wwreg_next = mvalid & mwreg & (mdestReg != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            wwreg    <= 1'b0;
            wdestReg <= '0;
            wbData   <= '0;
            wvalid   <= 1'b0;
            retired  <= '0;
        end else if (flush) begin
            wwreg    <= 1'b0;
            wdestReg <= '0;
            wbData   <= '0;
            wvalid   <= 1'b0;
        end else if (!stall) begin
            wwreg    <= wwreg_next;
            wdestReg <= mdestReg;
            wbData   <= wb_next;
            wvalid   <= mvalid;
            retired  <= retired + CNT_W'(mvalid);
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic against a
// behavioural model of the write-back rules (CNT_W=4 so counter wrap is reachable).
module tb_wb_stage;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst, mvalid, mwreg, mm2reg, mlsigned, stall, flush;
    logic [4:0]  mdestReg;
    logic [31:0] mr, mdo;
    logic [1:0]  mlsize;
    logic        wwreg, wvalid;
    logic [4:0]  wdestReg;
    logic [31:0] wbData;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    logic        e_wwreg, e_wvalid;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    int          e_ret;

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .mvalid   (mvalid),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mdestReg (mdestReg),
        .mr       (mr),
        .mdo      (mdo),
        .mlsize   (mlsize),
        .mlsigned (mlsigned),
        .stall    (stall),
        .flush    (flush),
        .wwreg    (wwreg),
        .wdestReg (wdestReg),
        .wbData   (wbData),
        .wvalid   (wvalid),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Reference load value: shift the addressed field down, then extend arithmetically.
    function automatic logic [31:0] ref_load(logic [31:0] d, logic [1:0] off,
                                             logic [1:0] sz, logic sg);
        logic [31:0] v;
        int bits;
        if (sz == 2'b01) begin
            bits = 16;
            v = (d >> (16 * (1 - int'(off[1])))) & 32'hFFFF;
        end else if (sz == 2'b10) begin
            bits = 8;
            v = (d >> (8 * (3 - int'(off)))) & 32'hFF;
        end else begin
            return d;
        end
        if (sg && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    // Advance the model from the currently driven inputs, clock once, compare outputs.
    task automatic cycle(input string tag);
        if (rst) begin
            e_wwreg = 0; e_dest = 0; e_data = 0; e_wvalid = 0; e_ret = 0;
        end else if (flush) begin
            e_wwreg = 0; e_dest = 0; e_data = 0; e_wvalid = 0;
        end else if (!stall) begin
            e_wvalid = mvalid;
            e_wwreg  = mvalid && mwreg && mdestReg != 0;
            e_dest   = mdestReg;
            e_data   = mm2reg ? ref_load(mdo, mr[1:0], mlsize, mlsigned) : mr;
            e_ret    = (e_ret + (mvalid ? 1 : 0)) % (1 << CNT_W);
        end
        @(posedge clk);
        #1;
        check({tag, ".wwreg"},    32'(wwreg),    32'(e_wwreg));
        check({tag, ".wdestReg"}, 32'(wdestReg), 32'(e_dest));
        check({tag, ".wbData"},   wbData,        e_data);
        check({tag, ".wvalid"},   32'(wvalid),   32'(e_wvalid));
        check({tag, ".retired"},  32'(retired),  32'(e_ret));
    endtask

    task automatic randomize_mem();
        mvalid   = 1'($urandom);
        mwreg    = 1'($urandom);
        mm2reg   = 1'($urandom);
        mdestReg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        mr       = $urandom;
        mdo      = $urandom;
        mlsize   = 2'($urandom);
        mlsigned = 1'($urandom);
    endtask

    task automatic set_mem(input logic v, input logic w, input logic m2r, input logic [4:0] d,
                           input logic [31:0] r, input logic [31:0] o,
                           input logic [1:0] sz, input logic sg);
        mvalid = v; mwreg = w; mm2reg = m2r; mdestReg = d;
        mr = r; mdo = o; mlsize = sz; mlsigned = sg;
    endtask

    initial begin
        e_wwreg = 0; e_dest = 0; e_data = 0; e_wvalid = 0; e_ret = 0;
        stall = 0; flush = 0;
        randomize_mem();

        rst = 1;
        for (int i = 0; i < 2; i++) begin
            randomize_mem();
            cycle("reset");
        end
        check("reset.wbData_zero", wbData, 32'h0);
        rst = 0;

        set_mem(1, 1, 0, 5'd8, 32'hDEADBEEF, 32'h0, 2'b00, 0);
        cycle("alu_wb");
        check("alu_wb.retired_one", 32'(retired), 32'd1);
        check("alu_wb.data_const", wbData, 32'hDEADBEEF);

        set_mem(1, 1, 1, 5'd9, 32'h1000, 32'h80FF7F01, 2'b10, 1);
        cycle("sbyte_off0");
        check("sbyte_off0.const", wbData, 32'hFFFFFF80);
        set_mem(1, 1, 1, 5'd10, 32'h1002, 32'h80FF7F01, 2'b10, 0);
        cycle("ubyte_off2");
        check("ubyte_off2.const", wbData, 32'h0000007F);
        set_mem(1, 1, 1, 5'd11, 32'h1002, 32'h80FF7F01, 2'b01, 1);
        cycle("shalf_off2");
        check("shalf_off2.const", wbData, 32'h00007F01);
        set_mem(1, 1, 1, 5'd12, 32'h1003, 32'h80FF7F01, 2'b11, 1);
        cycle("reserved_size");

        set_mem(1, 1, 0, 5'd0, 32'h12345678, 32'h0, 2'b00, 0);
        cycle("reg_zero");
        set_mem(0, 1, 0, 5'd5, 32'h55, 32'h0, 2'b00, 0);
        cycle("bubble_no_write");

        set_mem(1, 1, 0, 5'd7, 32'hA5A5A5A5, 32'h0, 2'b00, 0);
        cycle("pre_stall");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_mem();
            cycle("stall");
        end
        flush = 1;
        randomize_mem();
        cycle("flush_and_stall");
        flush = 0;
        randomize_mem();
        rst = 1;
        cycle("reset_mid_stall");
        rst = 0; stall = 0;

        for (int i = 0; i < 17; i++) begin
            set_mem(1, 1, 0, 5'd3, 32'(i), 32'h0, 2'b00, 0);
            cycle("wrap");
        end
        check("wrap.retired_one", 32'(retired), 32'd1);

        for (int i = 0; i < 400; i++) begin
            randomize_mem();
            rst   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 4) == 0);
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
